main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm_pkg.sv | 52 +++++
 rtl/main_fsm_imm_dec.sv | 23 ++
 rtl/main_fsm.sv | 151 +++++++++++++++
 tb/tb_main_fsm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// Shared state encoding, opcodes and datapath select encodings for the
// multicycle RISC-V control FSM.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/main_fsm_imm_dec.sv
// Immediate-format select decoded purely from the opcode.
module imm_dec
  import main_fsm_pkg::*;
#(
  parameter int ENABLE_LUI = 1
) (
  input  logic [6:0] op_i,
  output logic [2:0] imm_src_o
);

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      // With LUI disabled the opcode is illegal and falls back to the default
      OP_LUI:  imm_src_o = (ENABLE_LUI != 0) ? IMM_U : IMM_I;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Moore control FSM for a multicycle RISC-V datapath with memory handshake,
// sticky illegal-opcode trap and retired-instruction counter.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ENABLE_LUI    = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q;
  logic             rdy;

  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Every instruction retires by returning to FETCH; TRAP never does
      if (state_q != FETCH && state_d == FETCH) instret_q <= instret_q + CNT_W'(1);
      if (state_d == TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (rdy) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          OP_LUI:       state_d = (ENABLE_LUI != 0) ? LUI : TRAP;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (rdy) state_d = MEMWB;
      MEMWRITE: if (rdy) state_d = FETCH;
      MEMWB, ALUWB, BEQ, LUI: state_d = FETCH;
      EXECR, EXECI, JAL:      state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = TRAP;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        // IR and PC load only on the cycle the instruction word arrives
        IRWrite   = rdy;
        PCUpdate  = rdy;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR, EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = (state_q == EXECI) ? SRCB_IMM : SRCB_RS2;
        ALUOp   = ALUOP_FUNC;
      end
      ALUWB:    RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        Branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        PCUpdate = 1'b1;
      end
      LUI: begin
        ResultSrc = RES_IMM;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  imm_dec #(.ENABLE_LUI(ENABLE_LUI)) u_imm_dec (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

  assign state   = state_q;
  assign instret = instret_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: directed instruction sequences on a default
// instance and on a no-handshake / no-LUI / 4-bit-counter instance.
module tb_main_fsm;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8,  S_BEQ = 4'd9, S_JAL = 4'd10, S_LUI = 4'd11, S_TRAP = 4'd15;

  localparam logic [6:0] O_LW = 7'b0000011, O_SW = 7'b0100011, O_R = 7'b0110011, O_I = 7'b0010011;
  localparam logic [6:0] O_BEQ = 7'b1100011, O_JAL = 7'b1101111, O_LUI = 7'b0110111, O_ECALL = 7'b1110011;

  // {mem_req,PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  localparam logic [14:0] SB_F0  = 15'b1000000_10_00_10_00;
  localparam logic [14:0] SB_F1  = 15'b1100010_10_00_10_00;
  localparam logic [14:0] SB_DEC = 15'b0000000_00_01_01_00;
  localparam logic [14:0] SB_MA  = 15'b0000000_00_10_01_00;
  localparam logic [14:0] SB_MR  = 15'b1000001_00_00_00_00;
  localparam logic [14:0] SB_MWB = 15'b0001000_01_00_00_00;
  localparam logic [14:0] SB_MW  = 15'b1000101_00_00_00_00;
  localparam logic [14:0] SB_XR  = 15'b0000000_00_10_00_10;
  localparam logic [14:0] SB_XI  = 15'b0000000_00_10_01_10;
  localparam logic [14:0] SB_AWB = 15'b0001000_00_00_00_00;
  localparam logic [14:0] SB_BEQ = 15'b0010000_00_10_00_01;
  localparam logic [14:0] SB_JAL = 15'b0100000_00_01_10_00;
  localparam logic [14:0] SB_LUI = 15'b0001000_11_00_00_00;
  localparam logic [14:0] SB_TRP = 15'b0000000_00_00_00_00;

  typedef struct {
    string       lbl;
    logic        sel;
    logic [3:0]  st;
    logic [14:0] sb;
    logic [2:0]  imm;
    logic        ill;
    logic [31:0] ir;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic [6:0] op;
  logic mem_ready;

  logic        a_mreq, a_pcu, a_br, a_rw, a_mw, a_irw, a_adr, a_ill;
  logic [1:0]  a_res, a_sa, a_sb, a_aop;
  logic [2:0]  a_imm;
  logic [31:0] a_ir;
  logic [3:0]  a_st;

  logic        b_mreq, b_pcu, b_br, b_rw, b_mw, b_irw, b_adr, b_ill;
  logic [1:0]  b_res, b_sa, b_sb, b_aop;
  logic [2:0]  b_imm;
  logic [3:0]  b_ir;
  logic [3:0]  b_st;

  always #5 clk = ~clk;

  main_fsm dut_a (
    .clk(clk), .resetn(resetn), .op(op), .mem_ready(mem_ready),
    .mem_req(a_mreq), .PCUpdate(a_pcu), .Branch(a_br), .RegWrite(a_rw),
    .MemWrite(a_mw), .IRWrite(a_irw), .AdrSrc(a_adr), .ResultSrc(a_res),
    .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUOp(a_aop), .ImmSrc(a_imm),
    .illegal(a_ill), .instret(a_ir), .state(a_st)
  );

  main_fsm #(.MEM_HANDSHAKE(0), .ENABLE_LUI(0), .CNT_W(4)) dut_b (
    .clk(clk), .resetn(resetn), .op(op), .mem_ready(mem_ready),
    .mem_req(b_mreq), .PCUpdate(b_pcu), .Branch(b_br), .RegWrite(b_rw),
    .MemWrite(b_mw), .IRWrite(b_irw), .AdrSrc(b_adr), .ResultSrc(b_res),
    .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUOp(b_aop), .ImmSrc(b_imm),
    .illegal(b_ill), .instret(b_ir), .state(b_st)
  );

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic        sel = 1'b0;
  logic        ready_lvl = 1'b1;
  logic [2:0]  cur_imm = 3'b000;
  logic        exp_ill = 1'b0;
  logic [31:0] exp_ir = 0;

  // Monitor: one scoreboard entry per sampled cycle, compared at negedge
  always @(negedge clk) begin
    if (q.size() != 0) begin
      logic [3:0]  g_st;
      logic [14:0] g_sb;
      logic [2:0]  g_imm;
      logic        g_ill;
      logic [31:0] g_ir;
      logic [31:0] x_ir;
      e = q.pop_front();
      if (e.sel) begin
        g_st = b_st; g_imm = b_imm; g_ill = b_ill; g_ir = {28'd0, b_ir};
        g_sb = {b_mreq, b_pcu, b_br, b_rw, b_mw, b_irw, b_adr, b_res, b_sa, b_sb, b_aop};
        x_ir = e.ir & 32'hF;
      end else begin
        g_st = a_st; g_imm = a_imm; g_ill = a_ill; g_ir = a_ir;
        g_sb = {a_mreq, a_pcu, a_br, a_rw, a_mw, a_irw, a_adr, a_res, a_sa, a_sb, a_aop};
        x_ir = e.ir;
      end
      n_tests++;
      if (g_st !== e.st || g_sb !== e.sb || g_imm !== e.imm || g_ill !== e.ill || g_ir !== x_ir) begin
        n_fail++;
        $display("FAIL %s: got st=%0d sb=%b imm=%b ill=%b instret=%0d, want st=%0d sb=%b imm=%b ill=%b instret=%0d",
                 e.lbl, g_st, g_sb, g_imm, g_ill, g_ir, e.st, e.sb, e.imm, e.ill, x_ir);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string l, input logic [3:0] st, input logic [14:0] sb);
    exp_t x;
    x.lbl = l; x.sel = sel; x.st = st; x.sb = sb;
    x.imm = cur_imm; x.ill = exp_ill; x.ir = exp_ir;
    q.push_back(x);
  endtask

  task automatic set_op(input logic [6:0] o, input logic [2:0] im);
    op = o;
    cur_imm = im;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    mem_ready = 1'b0;
    exp_ir = 0;
    exp_ill = 1'b0;
    for (int i = 0; i < n; i++) begin
      push("reset", S_FETCH, sel ? SB_F1 : SB_F0);
      tick();
    end
    resetn = 1'b1;
  endtask

  task automatic run(input string nm, input logic [6:0] o, input logic [2:0] im,
                     input int fw, input int mw);
    bit trapped = 0;
    set_op(o, im);
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0; push({nm, ":fetch_wait"}, S_FETCH, SB_F0); tick();
    end
    mem_ready = ready_lvl; push({nm, ":fetch"}, S_FETCH, SB_F1); tick();
    push({nm, ":decode"}, S_DECODE, SB_DEC); tick();
    case (o)
      O_LW: begin
        push({nm, ":memadr"}, S_MEMADR, SB_MA); tick();
        for (int i = 0; i < mw; i++) begin
          mem_ready = 1'b0; push({nm, ":memread_wait"}, S_MEMREAD, SB_MR); tick();
        end
        mem_ready = ready_lvl; push({nm, ":memread"}, S_MEMREAD, SB_MR); tick();
        push({nm, ":memwb"}, S_MEMWB, SB_MWB); tick();
      end
      O_SW: begin
        push({nm, ":memadr"}, S_MEMADR, SB_MA); tick();
        for (int i = 0; i < mw; i++) begin
          mem_ready = 1'b0; push({nm, ":memwrite_wait"}, S_MEMWRITE, SB_MW); tick();
        end
        mem_ready = ready_lvl; push({nm, ":memwrite"}, S_MEMWRITE, SB_MW); tick();
      end
      O_R: begin
        push({nm, ":execr"}, S_EXECR, SB_XR); tick();
        push({nm, ":aluwb"}, S_ALUWB, SB_AWB); tick();
      end
      O_I: begin
        push({nm, ":execi"}, S_EXECI, SB_XI); tick();
        push({nm, ":aluwb"}, S_ALUWB, SB_AWB); tick();
      end
      O_BEQ: begin
        push({nm, ":beq"}, S_BEQ, SB_BEQ); tick();
      end
      O_JAL: begin
        push({nm, ":jal"}, S_JAL, SB_JAL); tick();
        push({nm, ":aluwb"}, S_ALUWB, SB_AWB); tick();
      end
      O_LUI: begin
        if (sel) trapped = 1;
        else begin
          push({nm, ":lui"}, S_LUI, SB_LUI); tick();
        end
      end
      default: trapped = 1;
    endcase
    if (trapped) begin
      exp_ill = 1'b1;
      for (int i = 0; i < 12; i++) begin
        push({nm, ":trap"}, S_TRAP, SB_TRP); tick();
      end
    end else begin
      exp_ir = exp_ir + 1;
    end
  endtask

  initial begin
    resetn = 1'b0;
    mem_ready = 1'b0;
    set_op(7'd0, 3'b000);
    tick();
    do_reset(2);

    // Zero-wait program: lw 5, sw 4, add 4, beq 3, jal 4, lui 3 cycles
    run("lw",  O_LW,  3'b000, 0, 0);
    run("sw",  O_SW,  3'b001, 0, 0);
    run("add", O_R,   3'b000, 0, 0);
    run("beq", O_BEQ, 3'b010, 0, 0);
    run("jal", O_JAL, 3'b011, 0, 0);
    run("lui", O_LUI, 3'b100, 0, 0);

    run("lw_fwait3", O_LW,  3'b000, 3, 0);
    run("sw_mwait2", O_SW,  3'b001, 0, 2);
    run("addi",      O_I,   3'b000, 0, 0);
    run("lw_mwait1", O_LW,  3'b000, 0, 1);

    // Reset asserted between edges while MEMREAD is waiting on memory
    set_op(O_LW, 3'b000);
    mem_ready = 1'b1; push("rst_mid:fetch", S_FETCH, SB_F1); tick();
    push("rst_mid:decode", S_DECODE, SB_DEC); tick();
    push("rst_mid:memadr", S_MEMADR, SB_MA); tick();
    mem_ready = 1'b0; push("rst_mid:memread", S_MEMREAD, SB_MR); tick();
    resetn = 1'b0;
    exp_ir = 0;
    push("rst_mid:async", S_FETCH, SB_F0); tick();
    resetn = 1'b1;

    run("beq_after_rst", O_BEQ, 3'b010, 0, 0);
    run("ecall", O_ECALL, 3'b000, 0, 0);
    do_reset(1);
    run("add_after_trap", O_R, 3'b000, 0, 0);

    // Second instance: memory always ready, LUI illegal, 4-bit counter
    sel = 1'b1;
    ready_lvl = 1'b0;
    set_op(O_BEQ, 3'b010);
    do_reset(1);
    for (int i = 0; i < 16; i++) run("b_beq", O_BEQ, 3'b010, 0, 0);
    run("b_lw", O_LW, 3'b000, 0, 0);
    run("b_sw", O_SW, 3'b001, 0, 0);
    run("b_lui", O_LUI, 3'b000, 0, 0);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
